// File: rtl/rx_word_buffer.sv
`default_nettype none
// ============================================================================
// Module      : rx_word_buffer
// Description : Packs good UART characters into multi-character words, with
//               the first-received character in the MS bits. Characters with
//               a parity or framing error discard the partial word. Completed
//               words go into a small FIFO. Sticky error and overflow flags
//               are provided.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_word_buffer #(
    parameter int DATA_W = 8,
    parameter int BYTES  = 2,
    parameter int DEPTH  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      valid,
    input  logic                      PERROR,
    input  logic                      FERROR,
    output logic [DATA_W*BYTES-1:0]   out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    fill,
    output logic                      perr_sticky,
    output logic                      ferr_sticky,
    output logic                      overflow,
    input  logic                      clear_err
);

    localparam int c_WORD_W = DATA_W * BYTES;
    localparam int c_PART_W = c_WORD_W - DATA_W;
    localparam int c_CNT_W  = $clog2(BYTES);
    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_FILL_W = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0]  c_LAST_CNT = c_CNT_W'(BYTES - 1);
    localparam logic [c_FILL_W-1:0] c_FULL     = c_FILL_W'(DEPTH);

    // Assembler state: characters already held, in arrival order (oldest highest)
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_PART_W-1:0] r_partial;

    // FIFO state
    logic [c_WORD_W-1:0] r_mem [0:DEPTH-1];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_FILL_W-1:0] r_fill;

    // Sticky flags
    logic r_perr;
    logic r_ferr;
    logic r_ovf;

    logic                w_good;
    logic                w_bad;
    logic                w_last;
    logic [c_WORD_W-1:0] w_word;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;

    // A strobe is a good character only when neither error flag accompanies it
    assign w_good = valid & ~PERROR & ~FERROR;
    assign w_bad  = valid & (PERROR | FERROR);
    assign w_last = w_good & (r_cnt == c_LAST_CNT);

    // Word formed by appending the incoming character below the held ones
    assign w_word = {r_partial, data_in};

    assign w_full = (r_fill == c_FULL);
    assign w_pop  = out_valid & out_ready;

    // A full FIFO can still accept a word when the head leaves on the same edge
    assign w_push = w_last & (~w_full | w_pop);
    assign w_drop = w_last & w_full & ~w_pop;

    // Character assembler: count good characters, flush on error or completion
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_partial <= '0;
        end else if (w_bad) begin
            r_cnt     <= '0;
            r_partial <= '0;
        end else if (w_good) begin
            if (w_last) begin
                r_cnt     <= '0;
                r_partial <= '0;
            end else begin
                r_cnt     <= r_cnt + 1'b1;
                r_partial <= w_word[c_PART_W-1:0];
            end
        end
    end

    // FIFO storage: written only on an accepted push, no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 DEPTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 1'b1;
                2'b01:   r_fill <= r_fill - 1'b1;
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Sticky flags: a new event wins over a coincident clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_perr <= (valid & PERROR) | (r_perr & ~clear_err);
            r_ferr <= (valid & FERROR) | (r_ferr & ~clear_err);
            r_ovf  <= w_drop | (r_ovf & ~clear_err);
        end
    end

    // Head word is forced to zero when empty so storage contents never leak out
    assign out_valid   = (r_fill != '0);
    assign out         = out_valid ? r_mem[r_rd_ptr] : '0;
    assign fill        = r_fill;
    assign perr_sticky = r_perr;
    assign ferr_sticky = r_ferr;
    assign overflow    = r_ovf;

endmodule
`default_nettype wire

// File: doc/rx_word_buffer.md
RX_WORD_BUFFER -- requirements
Module: rx_word_buffer

Parameters
REQ-001 SHALL have parameters (one per line: name, default, meaning):
- DATA_W, 8, bits per received character.
- BYTES, 2, characters packed per output word (>=2).
- DEPTH, 4, output FIFO depth in words (power of 2, >=2).

Interface
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on rising edge.
- reset, in, 1, asynchronous, active-low reset.
- data_in, in, DATA_W, received character from UART receiver.
- valid, in, 1, one-cycle strobe; data_in/PERROR/FERROR qualified.
- PERROR, in, 1, parity error on the strobed character.
- FERROR, in, 1, framing error on the strobed character.
- out, out, DATA_W*BYTES, FIFO head word.
- out_valid, out, 1, FIFO non-empty.
- out_ready, in, 1, consumer accepts head word.
- fill, out, $clog2(DEPTH)+1, words held in FIFO.
- perr_sticky, out, 1, parity error seen since last clear.
- ferr_sticky, out, 1, framing error seen since last clear.
- overflow, out, 1, word dropped because FIFO full since last clear.
- clear_err, in, 1, synchronous clear of the three sticky flags.

Function
REQ-003 SHALL treat each cycle with valid=1 as exactly one character; the producer pulses valid.
REQ-004 SHALL pack good characters (valid=1, PERROR=0, FERROR=0) first-received into the most-significant DATA_W bits of the word.
REQ-005 SHALL keep a character counter 0..BYTES-1; counter wraps to 0 when the BYTES-th good character completes a word.
REQ-006 SHALL, on a valid character with PERROR or FERROR high, discard that character and any partial word, reset counter to 0, and set the matching sticky flag(s) next cycle.
REQ-007 SHALL ignore PERROR/FERROR/data_in when valid=0.
REQ-008 SHALL push a completed word into the FIFO on the same edge the last character is sampled; out_valid rises on the following cycle if the FIFO was empty (latency 1 cycle from last strobe).
REQ-009 SHALL pop the head word on a rising edge with out_valid=1 and out_ready=1; out_ready with FIFO empty SHALL have no effect.
REQ-010 SHALL hold out stable while out_valid=1 and no pop occurs.
REQ-011 SHALL, on simultaneous push and pop, keep fill unchanged, including when full (push accepted).
REQ-012 SHALL, on push when full without pop, drop the new word, leave FIFO contents unchanged, and set overflow.
REQ-013 SHALL wrap FIFO read/write pointers modulo DEPTH; fill = DEPTH means full, 0 means empty.
REQ-014 SHALL give set priority over clear_err when an error/overflow event and clear_err coincide.

Reset
REQ-015 SHALL, while reset=0, asynchronously force counter=0, partial word=0, FIFO empty (fill=0, pointers 0), out_valid=0, out=0, perr_sticky=0, ferr_sticky=0, overflow=0.
REQ-016 SHALL discard any partial word and all buffered words when reset is asserted mid-operation; first character after release starts a new word.

Verification (DATA_W=8, BYTES=2, DEPTH=4)
REQ-017 Strobe 0xE3 then 0xFF -> one cycle after second strobe out_valid=1, out=0xE3FF, fill=1; out_ready=1 one cycle -> out_valid=0, fill=0.
REQ-018 Strobe 0x4D, strobe 0x11 with PERROR=1, strobe 0x00, 0x80 -> perr_sticky=1; only word 0x0080 buffered.
REQ-019 Errors asserted with valid=0 -> no flag set, counter unchanged.
REQ-020 Five words 0x0102,0x0304,0x0506,0x0708,0x090A, out_ready=0 -> fill=4, overflow=1, pops return 0x0102..0x0708 in order.
REQ-021 FIFO full, last character of new word coincides with out_ready=1 -> fill stays 4, overflow=0, new word appears last.
REQ-022 FERROR event and clear_err in same cycle -> ferr_sticky=1; reset=0 after one good character -> all outputs 0, next two characters form a fresh word.
